branch_sched: RTL

- Decode-stage control-transfer scheduler for the P5 pipeline. Classifies the instruction in D and holds it until its compare operands are forwarded-ready.
- Resolves the branch, jump or movz condition, then drives the PC redirect.
- Keeps the redirect asserted across fetch back-pressure, so a taken transfer is never lost while the delay slot is still being fetched.

---
 rtl/branch_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_sched.sv
`default_nettype none
// ============================================================================
// Module   : branch_sched
// Purpose  : Decode-stage control-transfer scheduler for the P5 pipeline.
//            Classifies the instruction in D (beq, bgezal, bltz, jr, jalr,
//            j, jal, movz) and holds D until its compare operands are
//            forwarded-ready. It then resolves the condition and drives the
//            PC redirect. A taken redirect stays asserted across fetch
//            back-pressure so it is never lost.
// Ports    : clk, reset (async, active-high)
//            instr_D, pc_D, d_valid       - instruction in D
//            rs_data/rt_data, *_ready     - forwarded operands
//            fetch_ready                  - F accepts the redirect
//            stall_D, redirect, redirect_pc, link_we, movz_we
//            br_cnt, taken_cnt, stall_cnt - performance counters
// Config   : `define BR_PERF_EN to build the saturating performance
//            counters; otherwise the counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module branch_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      pc_D,
  input  logic             d_valid,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             fetch_ready,
  output logic             stall_D,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             link_we,
  output logic             movz_we,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  localparam logic [5:0] c_op_special = 6'b000000;
  localparam logic [5:0] c_op_regimm  = 6'b000001;
  localparam logic [5:0] c_op_j       = 6'b000010;
  localparam logic [5:0] c_op_jal     = 6'b000011;
  localparam logic [5:0] c_op_beq     = 6'b000100;
  localparam logic [5:0] c_fn_jr      = 6'b001000;
  localparam logic [5:0] c_fn_jalr    = 6'b001001;
  localparam logic [5:0] c_fn_movz    = 6'b001010;
  localparam logic [4:0] c_rt_bltz    = 5'b00000;
  localparam logic [4:0] c_rt_bgezal  = 5'b10001;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_target;

  // ---------------- decode ----------------
  logic [5:0]  w_op;
  logic [4:0]  w_rtf;
  logic [5:0]  w_fn;
  logic        w_is_beq, w_is_bgezal, w_is_bltz, w_is_jr, w_is_jalr;
  logic        w_is_j, w_is_jal, w_is_movz;
  logic        w_is_branch, w_is_jreg, w_is_jabs, w_is_ctrl;
  logic        w_need_rs, w_need_rt, w_ready, w_taken, w_link;
  logic [31:0] w_pc_seq, w_br_off, w_target;
  logic        w_leave, w_leave_taken, w_latch;

  assign w_op  = instr_D[31:26];
  assign w_rtf = instr_D[20:16];
  assign w_fn  = instr_D[5:0];

  assign w_is_beq    = d_valid && (w_op == c_op_beq);
  assign w_is_bgezal = d_valid && (w_op == c_op_regimm) && (w_rtf == c_rt_bgezal);
  assign w_is_bltz   = d_valid && (w_op == c_op_regimm) && (w_rtf == c_rt_bltz);
  assign w_is_jr     = d_valid && (w_op == c_op_special) && (w_fn == c_fn_jr);
  assign w_is_jalr   = d_valid && (w_op == c_op_special) && (w_fn == c_fn_jalr);
  assign w_is_movz   = d_valid && (w_op == c_op_special) && (w_fn == c_fn_movz);
  assign w_is_j      = d_valid && (w_op == c_op_j);
  assign w_is_jal    = d_valid && (w_op == c_op_jal);

  assign w_is_branch = w_is_beq | w_is_bgezal | w_is_bltz;
  assign w_is_jreg   = w_is_jr | w_is_jalr;
  assign w_is_jabs   = w_is_j | w_is_jal;
  assign w_is_ctrl   = w_is_branch | w_is_jreg | w_is_jabs | w_is_movz;

  assign w_need_rs = w_is_branch | w_is_jreg;
  assign w_need_rt = w_is_beq | w_is_movz;
  assign w_ready   = (~w_need_rs | rs_ready) & (~w_need_rt | rt_ready);

  assign w_taken = (w_is_beq & (rs_data == rt_data)) |
                   (w_is_bgezal & ~rs_data[31]) |
                   (w_is_bltz & rs_data[31]) |
                   w_is_jreg | w_is_jabs;

  // bgezal links even when the branch falls through.
  assign w_link = w_is_jal | w_is_jalr | w_is_bgezal;

  assign w_pc_seq = pc_D + 32'd4;
  assign w_br_off = {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
  assign w_target = w_is_branch ? (w_pc_seq + w_br_off) :
                    w_is_jreg   ? rs_data :
                                  {w_pc_seq[31:28], instr_D[25:0], 2'b00};

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // The redirect target is captured when a taken transfer meets fetch
  // back-pressure; in HOLD the instruction fields in D are no longer trusted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_target <= 32'd0;
    else if (w_latch) r_target <= w_target;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_hold: begin
        if (fetch_ready) w_state_nxt = c_st_idle;
      end
      // IDLE and WAIT resolve identically; a flush in WAIT shows up as a
      // non-control instruction and drops back to IDLE.
      default: begin
        if (!w_is_ctrl)                   w_state_nxt = c_st_idle;
        else if (!w_ready)                w_state_nxt = c_st_wait;
        else if (w_taken && !fetch_ready) w_state_nxt = c_st_hold;
        else                              w_state_nxt = c_st_idle;
      end
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    stall_D       = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'd0;
    link_we       = 1'b0;
    movz_we       = 1'b0;
    w_leave       = 1'b0;
    w_leave_taken = 1'b0;
    w_latch       = 1'b0;
    case (r_state)
      c_st_hold: begin
        redirect      = 1'b1;
        redirect_pc   = r_target;
        stall_D       = ~fetch_ready;
        w_leave       = fetch_ready;
        w_leave_taken = fetch_ready;
      end
      default: begin
        if (w_is_ctrl) begin
          if (!w_ready) begin
            stall_D = 1'b1;
          end else begin
            link_we = w_link;
            movz_we = w_is_movz & (rt_data == 32'd0);
            if (w_taken) begin
              redirect    = 1'b1;
              redirect_pc = w_target;
              stall_D     = ~fetch_ready;
              w_latch     = ~fetch_ready;
            end
            // A taken transfer blocked by fetch leaves D from HOLD instead.
            w_leave       = ~w_taken | fetch_ready;
            w_leave_taken = w_taken & fetch_ready;
          end
        end
      end
    endcase
  end

  // ---------------- performance counters ----------------
`ifdef BR_PERF_EN
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_br_cnt, r_taken_cnt, r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_leave && (r_br_cnt != c_cnt_max))
        r_br_cnt <= r_br_cnt + c_cnt_one;
      if (w_leave_taken && (r_taken_cnt != c_cnt_max))
        r_taken_cnt <= r_taken_cnt + c_cnt_one;
      if (stall_D && (r_stall_cnt != c_cnt_max))
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = ^{w_leave, w_leave_taken};
  assign br_cnt    = '0;
  assign taken_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
